// File: rtl/pe_result_packer.sv
// pe_result_packer
//   Collects one row of eight 16-bit PE results per pe_vld beat, buffers the
//   rows in a small FIFO and serialises each row as four 32-bit words onto a
//   sop/eop/vld packet stream. The output has no backpressure; a row that
//   arrives while the FIFO is full (and no pop happens that edge) is dropped
//   and the sticky ovf flag is raised.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   pe_vld, pe_last       row valid / row closes the result packet
//   pe_data_0..7 [15:0]   PE results, PE index 0..7
//   ovf_clr               clears the ovf sticky flag (a same-cycle drop wins)
//   out_sop, out_eop      first / last word of packet
//   out_vld, out_data     registered word stream, data holds when not valid
//   busy                  FIFO non-empty or a row is being sent
//   ovf                   sticky: at least one row was dropped
module pe_result_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pe_vld,
  input  logic        pe_last,
  input  logic [15:0] pe_data_0,
  input  logic [15:0] pe_data_1,
  input  logic [15:0] pe_data_2,
  input  logic [15:0] pe_data_3,
  input  logic [15:0] pe_data_4,
  input  logic [15:0] pe_data_5,
  input  logic [15:0] pe_data_6,
  input  logic [15:0] pe_data_7,
  input  logic        ovf_clr,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_vld,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        ovf
);

  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_SEND  = 1'b1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

  // Row storage: {pe_last, pe_data_7 .. pe_data_0}; PE k sits at bits [16k+15:16k]
  // so word w of a row is simply bits [32w+31:32w].
  logic [128:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic [0:0]       state_q,  state_d;
  logic [1:0]       idx_q,    idx_d;
  logic             in_pkt_q, in_pkt_d;
  logic             ovf_q,    ovf_d;
  logic             sop_q,    sop_d;
  logic             eop_q,    eop_d;
  logic             vld_q,    vld_d;
  logic [31:0]      data_q,   data_d;

  logic [128:0] head_row;
  logic [1:0]   cur_idx;
  logic         emit;
  logic         pop;
  logic         push;
  logic         drop;

  assign head_row = mem_q[rd_ptr_q];

  // A word is registered every edge while sending, and on the IDLE edge that
  // sees a waiting row (that edge always registers word0).
  assign emit    = (state_q == ST_SEND) || (count_q != '0);
  assign cur_idx = (state_q == ST_SEND) ? idx_q : 2'd0;
  assign pop     = emit && (cur_idx == 2'd3);
  // A full FIFO still accepts when the head row leaves on the same edge.
  assign push    = pe_vld && ((count_q != CNT_FULL) || pop);
  assign drop    = pe_vld && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = ST_IDLE;
    idx_d    = 2'd0;
    in_pkt_d = in_pkt_q;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    vld_d    = 1'b0;
    data_d   = data_q;
    ovf_d    = drop | (ovf_q & ~ovf_clr);

    if (push) begin
      wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (pop) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (emit) begin
      vld_d  = 1'b1;
      data_d = head_row[{cur_idx, 5'd0} +: 32];
      if (cur_idx == 2'd0) begin
        sop_d    = ~in_pkt_q;
        in_pkt_d = 1'b1;
      end
      if (cur_idx == 2'd3) begin
        eop_d = head_row[128];
        if (head_row[128]) begin
          in_pkt_d = 1'b0;
        end
        // Another row already queued behind the head: continue without a gap.
        state_d = (count_q >= CNT_TWO) ? ST_SEND : ST_IDLE;
        idx_d   = 2'd0;
      end else begin
        state_d = ST_SEND;
        idx_d   = 2'(cur_idx + 2'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pe_last, pe_data_7, pe_data_6, pe_data_5, pe_data_4,
                          pe_data_3, pe_data_2, pe_data_1, pe_data_0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      in_pkt_q <= 1'b0;
      ovf_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      in_pkt_q <= in_pkt_d;
      ovf_q    <= ovf_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
    end
  end

  assign out_sop  = sop_q;
  assign out_eop  = eop_q;
  assign out_vld  = vld_q;
  assign out_data = data_q;
  assign ovf      = ovf_q;
  assign busy     = (count_q != '0) | (state_q == ST_SEND);

endmodule

// File: tb/tb_pe_result_packer.sv
module tb_pe_result_packer;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pe_vld = 1'b0;
  logic        pe_last = 1'b0;
  logic [15:0] pd [8];
  logic        ovf_clr = 1'b0;
  logic        out_sop, out_eop, out_vld, busy, ovf;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  pe_result_packer #(.FIFO_DEPTH(D), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .pe_vld(pe_vld), .pe_last(pe_last),
    .pe_data_0(pd[0]), .pe_data_1(pd[1]), .pe_data_2(pd[2]), .pe_data_3(pd[3]),
    .pe_data_4(pd[4]), .pe_data_5(pd[5]), .pe_data_6(pd[6]), .pe_data_7(pd[7]),
    .ovf_clr(ovf_clr), .out_sop(out_sop), .out_eop(out_eop), .out_vld(out_vld),
    .out_data(out_data), .busy(busy), .ovf(ovf)
  );

  // Reference model: each accepted row gets the cycle its word0 is visible,
  // start = max(push_cycle + 2, previous_start + 4); it leaves the FIFO at the
  // end of cycle start+2. Everything else is derived from that schedule.
  typedef struct {
    int           p;
    int           s;
    logic [127:0] d;
    logic         sop;
    logic         eop;
  } row_t;

  row_t rows[$];
  int   cyc;
  int   last_start;
  logic m_inpkt, m_ovf, m_ovf_next;
  int   passed, total;
  int   vld_cnt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [127:0] make_data(logic [15:0] base);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = base + 16'(k);
    return r;
  endfunction

  task automatic model_clear();
    rows.delete();
    last_start = -100;
    m_inpkt = 1'b0;
    m_ovf = 1'b0;
    m_ovf_next = 1'b0;
    cyc = 0;
  endtask

  // Drive inputs for the current cycle and update the model's accept/drop view.
  task automatic apply(logic vld, logic last, logic [127:0] d, logic clr);
    int   cnt;
    bit   popping;
    bit   dropped;
    row_t r;
    pe_vld = vld;
    pe_last = last;
    ovf_clr = clr;
    for (int k = 0; k < 8; k++) pd[k] = d[16*k +: 16];
    cnt = 0;
    popping = 0;
    dropped = 0;
    foreach (rows[i]) begin
      if (rows[i].p < cyc && rows[i].s + 2 >= cyc) cnt++;
      if (rows[i].s + 2 == cyc) popping = 1;
    end
    if (vld) begin
      if (cnt < D || popping) begin
        r.p = cyc;
        r.s = (cyc + 2 > last_start + 4) ? cyc + 2 : last_start + 4;
        r.d = d;
        r.sop = ~m_inpkt;
        r.eop = last;
        m_inpkt = ~last;
        last_start = r.s;
        rows.push_back(r);
      end else begin
        dropped = 1;
      end
    end
    m_ovf_next = dropped | (m_ovf & ~clr);
  endtask

  task automatic check_model();
    logic        ev, es, ee, eb;
    logic [31:0] ed;
    int          w;
    ev = 0; es = 0; ee = 0; eb = 0; ed = 32'h0;
    foreach (rows[i]) begin
      if (rows[i].s + 3 < cyc) ed = rows[i].d[127:96];
      if (rows[i].s <= cyc && cyc <= rows[i].s + 3) begin
        w = cyc - rows[i].s;
        ev = 1;
        ed = rows[i].d[32*w +: 32];
        es = rows[i].sop && (w == 0);
        ee = rows[i].eop && (w == 3);
      end
      if (rows[i].p < cyc && cyc <= rows[i].s + 2) eb = 1;
    end
    if (out_vld === 1'b1) vld_cnt++;
    check("out_vld", 32'(out_vld), 32'(ev));
    check("out_sop", 32'(out_sop), 32'(es));
    check("out_eop", 32'(out_eop), 32'(ee));
    check("out_data", out_data, ed);
    check("busy", 32'(busy), 32'(eb));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    m_ovf = m_ovf_next;
  endtask

  task automatic step(logic vld, logic last, logic [127:0] d, logic clr);
    apply(vld, last, d, clr);
    @(negedge clk);
    check_model();
    advance();
  endtask

  // Asynchronous reset: outputs must clear immediately, without a clock edge.
  task automatic do_reset();
    pe_vld = 0; pe_last = 0; ovf_clr = 0;
    rst_n = 1'b0;
    #2;
    check("rst_out_vld", 32'(out_vld), 32'h0);
    check("rst_out_sop", 32'(out_sop), 32'h0);
    check("rst_out_eop", 32'(out_eop), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  typedef struct {
    bit          rst;
    bit          vld;
    bit          last;
    logic [15:0] base;
    bit          ev, es, ee;
    logic [31:0] ed;
  } vec_t;

  vec_t vt [17];

  initial begin
    passed = 0; total = 0; vld_cnt = 0;
    for (int k = 0; k < 8; k++) pd[k] = 16'h0;
    model_clear();

    // Single pe_last row, then two-row packet with the second row at cycle 4.
    vt[0]  = '{1, 1, 1, 16'h1000, 0, 0, 0, 32'h00000000};
    vt[1]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 32'h00000000};
    vt[2]  = '{0, 0, 0, 16'h0000, 1, 1, 0, 32'h10011000};
    vt[3]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 32'h10031002};
    vt[4]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 32'h10051004};
    vt[5]  = '{0, 0, 0, 16'h0000, 1, 0, 1, 32'h10071006};
    vt[6]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 32'h10071006};
    vt[7]  = '{1, 1, 0, 16'h1000, 0, 0, 0, 32'h00000000};
    vt[8]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 32'h00000000};
    vt[9]  = '{0, 0, 0, 16'h0000, 1, 1, 0, 32'h10011000};
    vt[10] = '{0, 0, 0, 16'h0000, 1, 0, 0, 32'h10031002};
    vt[11] = '{0, 1, 1, 16'h2000, 1, 0, 0, 32'h10051004};
    vt[12] = '{0, 0, 0, 16'h0000, 1, 0, 0, 32'h10071006};
    vt[13] = '{0, 0, 0, 16'h0000, 1, 0, 0, 32'h20012000};
    vt[14] = '{0, 0, 0, 16'h0000, 1, 0, 0, 32'h20032002};
    vt[15] = '{0, 0, 0, 16'h0000, 1, 0, 0, 32'h20052004};
    vt[16] = '{0, 0, 0, 16'h0000, 1, 0, 1, 32'h20072006};

    #1;
    for (int i = 0; i < 17; i++) begin
      if (vt[i].rst) do_reset();
      apply(vt[i].vld, vt[i].last, vt[i].vld ? make_data(vt[i].base) : 128'h0, 1'b0);
      @(negedge clk);
      check_model();
      check("tbl_vld", 32'(out_vld), 32'(vt[i].ev));
      check("tbl_sop", 32'(out_sop), 32'(vt[i].es));
      check("tbl_eop", 32'(out_eop), 32'(vt[i].ee));
      check("tbl_data", out_data, vt[i].ed);
      $display("vec %0d cycle %0d: vld=%b sop=%b eop=%b data=%h", i, cyc, out_vld, out_sop, out_eop, out_data);
      advance();
    end

    // Overflow: eight back-to-back rows, rows 5..7 must be dropped.
    do_reset();
    vld_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (i < 8) step(1'b1, 1'b0, make_data(16'hA000 + 16'(i * 16)), 1'b0);
      else       step(1'b0, 1'b0, 128'h0, 1'b0);
    end
    check("ovf_words", 32'(vld_cnt), 32'd20);
    check("ovf_set", 32'(ovf), 32'h1);
    $display("overflow: words=%0d ovf=%b", vld_cnt, ovf);
    step(1'b0, 1'b0, 128'h0, 1'b1);
    check("ovf_cleared", 32'(ovf), 32'h0);
    // Refill; the sixth push is dropped in the same cycle ovf_clr is high.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, make_data(16'hB000 + 16'(i * 16)), i == 5);
    check("ovf_set_wins", 32'(ovf), 32'h1);
    $display("ovf after clr+drop: %b", ovf);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 128'h0, 1'b0);

    // Reset in the middle of a two-row packet, then a fresh single-row packet.
    do_reset();
    step(1'b1, 1'b0, make_data(16'hC000), 1'b0);
    step(1'b1, 1'b1, make_data(16'hC100), 1'b0);
    step(1'b0, 1'b0, 128'h0, 1'b0);
    step(1'b0, 1'b0, 128'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(i == 0, i == 0, make_data(16'hD000), 1'b0);
      @(negedge clk);
      check_model();
      if (i == 2) check("post_rst_sop", 32'(out_sop), 32'h1);
      if (i == 5) check("post_rst_eop", 32'(out_eop), 32'h1);
      $display("post-reset cycle %0d: vld=%b sop=%b eop=%b data=%h", cyc, out_vld, out_sop, out_eop, out_data);
      advance();
    end

    // Second row arrives while the first row's word3 is on the output.
    do_reset();
    vld_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      apply(i == 0 || i == 5, i == 5, make_data(i == 0 ? 16'hE000 : 16'hE100), 1'b0);
      @(negedge clk);
      check_model();
      if (i == 6) check("bubble", 32'(out_vld), 32'h0);
      advance();
    end
    check("bubble_words", 32'(vld_cnt), 32'd8);
    $display("bubble case: words=%0d", vld_cnt);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 2) == 0,
           {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 128'h0, 1'b0);
    $display("random phase done at cycle %0d", cyc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
